instr_mem_loader_mod: RTL and testbench

- Instruction-side responder for the one-cycle RISC.
- Takes the byte address produced by the program counter and returns the 32-bit instruction word combinationally in the same cycle.
- Contains a byte-stream loader FSM that fills the instruction memory before or between program runs.
- Stalls the core while a load is in progress.

---
 rtl/instr_mem_loader_mod.sv | 105 ++++++++++
 tb/tb_instr_mem_loader_mod.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader_mod.sv
// Instruction memory with a combinational read port for the single-cycle core
// and a little-endian byte-stream loader that stalls the core while it fills.
module instr_mem_loader_mod #(
    parameter int          N        = 10,
    parameter int          DEPTH    = 2**(N-2),
    parameter logic [31:0] NOP_WORD = 32'h00000013
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] pc_i,
    output logic [31:0]  instr_o,
    output logic         misaligned_o,
    input  logic         load_start_i,
    input  logic [N-2:0] load_words_i,
    input  logic         byte_valid_i,
    input  logic [7:0]   byte_i,
    output logic         byte_ready_o,
    output logic         load_busy_o,
    output logic         load_done_o
);

    typedef enum logic {IDLE, LOAD} state_t;

    localparam logic [N-2:0] DEPTH_W = (N-1)'(DEPTH);
    localparam logic [N-2:0] ONE_W   = (N-1)'(1);

    state_t       state;
    logic [1:0]   byte_cnt;
    logic [N-3:0] word_ptr;
    logic [N-2:0] remaining;
    logic [23:0]  asm_q;
    logic [31:0]  mem [DEPTH];

    logic         xfer;
    logic         word_wr;
    logic [31:0]  wr_word;
    logic [N-2:0] start_cnt;

    assign xfer      = byte_ready_o & byte_valid_i;
    assign word_wr   = xfer & (byte_cnt == 2'd3);
    assign wr_word   = {byte_i, asm_q};
    assign start_cnt = (load_words_i > DEPTH_W) ? DEPTH_W : load_words_i;

    // Storage is deliberately left out of reset so a reset keeps the program.
    always_ff @(posedge clk) begin
        if (word_wr) begin
            mem[word_ptr] <= wr_word;
        end
    end

    assign instr_o      = (state == LOAD) ? NOP_WORD : mem[pc_i[N-1:2]];
    assign misaligned_o = |pc_i[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            byte_cnt     <= '0;
            word_ptr     <= '0;
            remaining    <= '0;
            asm_q        <= '0;
            byte_ready_o <= 1'b0;
            load_busy_o  <= 1'b0;
            load_done_o  <= 1'b0;
        end else begin
            load_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_start_i && load_words_i != '0) begin
                        state        <= LOAD;
                        remaining    <= start_cnt;
                        word_ptr     <= '0;
                        byte_cnt     <= '0;
                        byte_ready_o <= 1'b1;
                        load_busy_o  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0:    asm_q[7:0]   <= byte_i;
                            2'd1:    asm_q[15:8]  <= byte_i;
                            2'd2:    asm_q[23:16] <= byte_i;
                            default: ;
                        endcase
                        if (byte_cnt == 2'd3) begin
                            remaining <= remaining - ONE_W;
                            // Pointer is held on the last word so it never wraps.
                            if (remaining == ONE_W) begin
                                state        <= IDLE;
                                byte_ready_o <= 1'b0;
                                load_busy_o  <= 1'b0;
                                load_done_o  <= 1'b1;
                            end else begin
                                word_ptr <= word_ptr + 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader_mod.sv
// Scoreboard bench for instr_mem_loader_mod: stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_instr_mem_loader_mod;

    localparam int N = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] pc_i;
    logic [31:0]  instr_o;
    logic         misaligned_o;
    logic         load_start_i;
    logic [N-2:0] load_words_i;
    logic         byte_valid_i;
    logic [7:0]   byte_i;
    logic         byte_ready_o;
    logic         load_busy_o;
    logic         load_done_o;

    instr_mem_loader_mod #(.N(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_i         (pc_i),
        .instr_o      (instr_o),
        .misaligned_o (misaligned_o),
        .load_start_i (load_start_i),
        .load_words_i (load_words_i),
        .byte_valid_i (byte_valid_i),
        .byte_i       (byte_i),
        .byte_ready_o (byte_ready_o),
        .load_busy_o  (load_busy_o),
        .load_done_o  (load_done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          sel;
        string       nm;
        logic [31:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   xfer_cnt = 0;
    int   done_cnt = 0;
    int   last_done_cyc = -1;
    int   t0 = 0;
    int   dbase = 0;
    int   xb = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        if (byte_valid_i === 1'b1 && byte_ready_o === 1'b1) xfer_cnt++;
        if (load_done_o === 1'b1) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.sel)
                0:       act = instr_o;
                1:       act = {31'b0, misaligned_o};
                2:       act = {31'b0, byte_ready_o};
                3:       act = {31'b0, load_busy_o};
                4:       act = {31'b0, load_done_o};
                5:       act = 32'(done_cnt);
                6:       act = 32'(xfer_cnt);
                7:       act = 32'(last_done_cyc);
                default: act = 'x;
            endcase
            n_cmp++;
            if (act !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %0h expected %0h", e.nm, act, e.v);
            end
        end
    end

    task automatic chk(input int sel, input string nm, input logic [31:0] v);
        exp_t e;
        e.sel = sel;
        e.nm  = nm;
        e.v   = v;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [N-2:0] n);
        load_start_i = 1'b1;
        load_words_i = n;
        step();
        load_start_i = 1'b0;
        t0 = cyc;
    endtask

    task automatic send(input logic [31:0] w, input bit toggle);
        for (int i = 0; i < 4; i++) begin
            if (toggle) begin
                byte_valid_i = 1'b0;
                chk(2, "ready_gap", 1);
                step();
            end
            byte_valid_i = 1'b1;
            byte_i       = w[8*i +: 8];
            pc_i         = N'($urandom);
            chk(0, "instr_nop", 32'h00000013);
            chk(2, "ready_load", 1);
            step();
        end
    endtask

    task automatic rd(input logic [N-1:0] a, input logic [31:0] v, input string nm);
        pc_i = a;
        chk(0, nm, v);
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        pc_i         = '0;
        load_start_i = 1'b0;
        load_words_i = '0;
        byte_valid_i = 1'b0;
        byte_i       = '0;
        #1;
        chk(2, "rst_ready", 0);
        chk(3, "rst_busy", 0);
        chk(4, "rst_done", 0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // two words, back-to-back bytes
        dbase = done_cnt;
        start_load(2);
        chk(3, "busy_load", 1);
        send(32'h00100513, 0);
        send(32'h00200593, 0);
        byte_valid_i = 1'b0;
        chk(4, "done_pulse", 1);
        chk(7, "done_lat8", 32'(t0 + 8));
        step();
        chk(4, "done_clr", 0);
        chk(5, "done_cnt1", 32'(dbase + 1));
        step();
        rd(10'h000, 32'h00100513, "w0_b2b");
        rd(10'h004, 32'h00200593, "w1_b2b");

        // same load, valid toggling
        start_load(2);
        send(32'h00100513, 1);
        send(32'h00200593, 1);
        byte_valid_i = 1'b0;
        chk(4, "done_pulse_tg", 1);
        chk(7, "done_lat16", 32'(t0 + 16));
        step();
        chk(5, "done_cnt2", 32'(dbase + 2));
        rd(10'h000, 32'h00100513, "w0_tg");
        rd(10'h004, 32'h00200593, "w1_tg");

        // zero-length load is ignored
        start_load(0);
        chk(2, "zero_ready", 0);
        chk(3, "zero_busy", 0);
        pc_i = 10'h006;
        chk(1, "misaligned", 1);
        chk(0, "instr_mis", 32'h00200593);
        step();
        pc_i = 10'h008;
        chk(1, "aligned", 0);
        chk(5, "done_cnt_zero", 32'(dbase + 2));
        step();

        // oversize load clamps to DEPTH
        xb = xfer_cnt;
        start_load(9'd300);
        for (int w = 0; w < 256; w++) begin
            send(32'hC0DE0000 | 32'(w), 0);
        end
        byte_i = 8'hFF;
        repeat (4) begin
            chk(2, "ready_after", 0);
            step();
        end
        byte_valid_i = 1'b0;
        chk(6, "xfer_1024", 32'(xb + 1024));
        chk(5, "done_cnt3", 32'(dbase + 3));
        step();
        rd(10'h000, 32'hC0DE0000, "clamp_w0");
        rd(10'h3FC, 32'hC0DE00FF, "clamp_w255");
        rd(10'h004, 32'hC0DE0001, "clamp_w1");

        // reset after six bytes of a three-word load
        start_load(3);
        send(32'h11223344, 0);
        for (int i = 0; i < 2; i++) begin
            byte_valid_i = 1'b1;
            byte_i       = (i == 0) ? 8'h88 : 8'h77;
            step();
        end
        byte_valid_i = 1'b0;
        rst_n        = 1'b0;
        chk(2, "async_ready", 0);
        chk(3, "async_busy", 0);
        chk(4, "async_done", 0);
        step();
        rst_n = 1'b1;
        step();
        rd(10'h000, 32'h11223344, "abort_w0");
        rd(10'h004, 32'hC0DE0001, "abort_w1");
        rd(10'h008, 32'hC0DE0002, "abort_w2");
        chk(5, "done_cnt_abort", 32'(dbase + 3));

        // restart at word 0, and a start on the done cycle is accepted
        start_load(1);
        send(32'hCAFEF00D, 0);
        byte_valid_i = 1'b0;
        pc_i         = 10'h000;
        chk(4, "done_restart", 1);
        chk(7, "done_lat4", 32'(t0 + 4));
        chk(0, "restart_w0", 32'hCAFEF00D);
        start_load(1);
        chk(3, "busy_chain", 1);
        send(32'h0BADF00D, 0);
        byte_valid_i = 1'b0;
        chk(4, "done_chain", 1);
        step();
        rd(10'h000, 32'h0BADF00D, "chain_w0");
        rd(10'h004, 32'hC0DE0001, "chain_w1");
        chk(5, "done_cnt_end", 32'(dbase + 5));
        step();
        step();

        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL pending: got %0d expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
